// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes,
// datapath select codes, instruction classes and the per-state control word.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] ALUB_REG  = 2'd0;
  localparam logic [1:0] ALUB_FOUR = 2'd1;
  localparam logic [1:0] ALUB_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // Bit positions of the one-hot instruction class vector.
  localparam int CLS_W   = 7;
  localparam int CL_R    = 0;
  localparam int CL_LW   = 1;
  localparam int CL_SW   = 2;
  localparam int CL_BEQ  = 3;
  localparam int CL_J    = 4;
  localparam int CL_HALT = 5;
  localparam int CL_NOP  = 6;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Control outputs that depend only on the state being entered and the class
  // latched at decode; these are registered one edge ahead.
  function automatic ctrl_t moore_ctrl(input state_t s, input logic [CLS_W-1:0] c);
    ctrl_t w;
    w = '0;
    case (s)
      S_IF: begin
        w.mem_rd    = 1'b1;
        w.alu_src_b = ALUB_FOUR;
        w.alu_op    = ALUOP_ADD;
      end
      S_ID: w.alu_src_b = ALUB_IMM;
      S_EX: begin
        if (c[CL_R]) begin
          w.alu_op = ALUOP_FUNCT;
        end else if (c[CL_LW] || c[CL_SW]) begin
          w.alu_src_b = ALUB_IMM;
          w.alu_op    = ALUOP_ADD;
        end else if (c[CL_BEQ]) begin
          w.alu_op = ALUOP_SUB;
        end
      end
      S_MEM: begin
        w.iord   = 1'b1;
        w.mem_rd = c[CL_LW];
        w.mem_we = c[CL_SW];
      end
      S_WB: begin
        w.reg_we     = 1'b1;
        w.reg_dst    = c[CL_R];
        w.mem_to_reg = c[CL_LW];
      end
      S_HALT: w.halted = 1'b1;
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode-to-class decoder: exactly one bit of cls_o is set for any opcode,
// with every unrecognised opcode falling into the NOP class.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic [5:0] opcode_i,
  output logic [6:0] cls_o
);

  always_comb begin
    cls_o = '0;
    if (opcode_i == OP_RTYPE) begin
      cls_o[CL_R] = 1'b1;
    end else if (opcode_i == OP_LW) begin
      cls_o[CL_LW] = 1'b1;
    end else if (opcode_i == OP_SW) begin
      cls_o[CL_SW] = 1'b1;
    end else if (opcode_i == OP_BEQ) begin
      cls_o[CL_BEQ] = 1'b1;
    end else if (opcode_i == OP_J) begin
      cls_o[CL_J] = 1'b1;
    end else if (opcode_i == HALT_OP) begin
      cls_o[CL_HALT] = 1'b1;
    end else begin
      cls_o[CL_NOP] = 1'b1;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for a MIPS-subset datapath.
// Stalls on mem_ready in fetch and memory states; HALT_OP parks it until reset.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0,
  parameter logic [5:0] HALT_OP     = 6'h3F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_we_o,
  output logic [1:0] pc_src_o,
  output logic       ir_we_o,
  output logic       mem_rd_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       reg_we_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [2:0] state_o,
  output logic       retire_o,
  output logic       halted_o
);

  state_t            state_q, state_d;
  logic [CLS_W-1:0]  cls_q, cls_d, cls_dec;
  ctrl_t             ctrl_q, ctrl_d;
  logic              pc_we_c, ir_we_c, retire_c;
  logic [1:0]        pc_src_c;
  logic              unused_funct;

  // funct is decoded by the ALU control, not by the sequencer.
  assign unused_funct = ^funct_i;

  mc_ctrl_decode #(.HALT_OP(HALT_OP)) u_decode (
    .opcode_i (opcode_i),
    .cls_o    (cls_dec)
  );

  assign cls_d = (state_q == S_ID) ? cls_dec : cls_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (mem_ready_i) state_d = S_ID;
      S_ID: begin
        if (cls_d[CL_J] || cls_d[CL_NOP]) state_d = S_IF;
        else if (cls_d[CL_HALT])          state_d = S_HALT;
        else                              state_d = S_EX;
      end
      S_EX: begin
        if (cls_d[CL_R])                      state_d = S_WB;
        else if (cls_d[CL_LW] || cls_d[CL_SW]) state_d = S_MEM;
        else                                  state_d = S_IF;
      end
      S_MEM: begin
        if (cls_d[CL_LW]) begin
          if (mem_ready_i) state_d = S_WB;
        end else if (cls_d[CL_SW]) begin
          if (mem_ready_i) state_d = S_IF;
        end else begin
          state_d = S_IF;
        end
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  assign ctrl_d = moore_ctrl(state_d, cls_d);

  // Handshake- and flag-dependent strobes stay combinational.
  always_comb begin
    pc_we_c  = 1'b0;
    pc_src_c = PC_SRC_SEQ;
    ir_we_c  = 1'b0;
    retire_c = 1'b0;
    case (state_q)
      S_IF: begin
        ir_we_c = mem_ready_i;
        pc_we_c = mem_ready_i;
      end
      S_ID: begin
        if (cls_d[CL_J]) begin
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_JMP;
        end
        retire_c = cls_d[CL_J] | cls_d[CL_NOP];
      end
      S_EX: begin
        if (cls_d[CL_BEQ]) begin
          retire_c = 1'b1;
          if (zero_i) begin
            pc_we_c  = 1'b1;
            pc_src_c = PC_SRC_BR;
          end
        end
      end
      S_MEM:   retire_c = cls_d[CL_SW] & mem_ready_i;
      S_WB:    retire_c = 1'b1;
      default: retire_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= state_t'(RESET_STATE);
      cls_q   <= '0;
      ctrl_q  <= moore_ctrl(state_t'(RESET_STATE), '0);
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Everything except the state is forced low while reset is held.
  assign state_o      = state_q;
  assign pc_we_o      = pc_we_c  & ~rst_i;
  assign pc_src_o     = pc_src_c & {2{~rst_i}};
  assign ir_we_o      = ir_we_c  & ~rst_i;
  assign retire_o     = retire_c & ~rst_i;
  assign mem_rd_o     = ctrl_q.mem_rd     & ~rst_i;
  assign mem_we_o     = ctrl_q.mem_we     & ~rst_i;
  assign iord_o       = ctrl_q.iord       & ~rst_i;
  assign reg_we_o     = ctrl_q.reg_we     & ~rst_i;
  assign reg_dst_o    = ctrl_q.reg_dst    & ~rst_i;
  assign mem_to_reg_o = ctrl_q.mem_to_reg & ~rst_i;
  assign alu_src_b_o  = ctrl_q.alu_src_b  & {2{~rst_i}};
  assign alu_op_o     = ctrl_q.alu_op     & {2{~rst_i}};
  assign halted_o     = ctrl_q.halted     & ~rst_i;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench: builds the expected per-cycle trace of each instruction
// from its class and stall counts, drives the inputs it implies, and compares.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_we, ir_we, mem_rd, mem_we, iord, reg_we, reg_dst, mem_to_reg;
  logic       retire, halted;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_rd;
    logic       mem_we;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       retire;
    logic       halted;
  } obs_t;

  typedef struct packed {
    logic       mr;
    logic       z;
    logic [5:0] op;
    int         id;
    obs_t       exp;
  } rec_t;

  obs_t obs;
  rec_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cur_id = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .opcode_i     (opcode),
    .funct_i      (funct),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .pc_we_o      (pc_we),
    .pc_src_o     (pc_src),
    .ir_we_o      (ir_we),
    .mem_rd_o     (mem_rd),
    .mem_we_o     (mem_we),
    .iord_o       (iord),
    .reg_we_o     (reg_we),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .state_o      (state),
    .retire_o     (retire),
    .halted_o     (halted)
  );

  assign obs = {state, pc_we, pc_src, ir_we, mem_rd, mem_we, iord, reg_we,
                reg_dst, mem_to_reg, alu_src_b, alu_op, retire, halted};

  // 0=R 1=LW 2=SW 3=BEQ 4=J 5=HALT 6=NOP
  function automatic int cls_of(input logic [5:0] op);
    case (op)
      6'h00:   return 0;
      6'h23:   return 1;
      6'h2B:   return 2;
      6'h04:   return 3;
      6'h02:   return 4;
      6'h3F:   return 5;
      default: return 6;
    endcase
  endfunction

  function automatic obs_t blank(input logic [2:0] s);
    obs_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic obs_t fetch_exp(input logic ready);
    obs_t e;
    e = blank(3'd0);
    e.mem_rd = 1'b1;
    e.asb    = 2'd1;
    e.ir_we  = ready;
    e.pc_we  = ready;
    return e;
  endfunction

  task automatic push(input logic mr, input logic [5:0] op, input logic z, input obs_t e);
    rec_t r;
    r.mr = mr; r.op = op; r.z = z; r.id = cur_id; r.exp = e;
    q.push_back(r);
  endtask

  task automatic add_instr(input logic [5:0] op, input int fst, input int mst,
                           input logic z, input int n_halt);
    int   k;
    obs_t e;
    k = cls_of(op);
    cur_id++;
    for (int i = 0; i < fst; i++) push(1'b0, 6'($urandom), 1'($urandom), fetch_exp(1'b0));
    push(1'b1, 6'($urandom), 1'($urandom), fetch_exp(1'b1));
    e = blank(3'd1);
    e.asb = 2'd2;
    if (k == 4) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
    e.retire = (k == 4) || (k == 6);
    push(1'($urandom), op, 1'($urandom), e);
    if (k == 5) begin
      for (int i = 0; i < n_halt; i++) begin
        e = blank(3'd5);
        e.halted = 1'b1;
        push(1'($urandom), op, 1'($urandom), e);
      end
    end
    if (k <= 3) begin
      e = blank(3'd2);
      if (k == 0) e.aop = 2'd2;
      if (k == 1 || k == 2) e.asb = 2'd2;
      if (k == 3) begin
        e.aop = 2'd1; e.retire = 1'b1; e.pc_we = z; e.pc_src = z ? 2'd1 : 2'd0;
      end
      push(1'($urandom), op, (k == 3) ? z : 1'($urandom), e);
    end
    if (k == 1 || k == 2) begin
      for (int i = 0; i <= mst; i++) begin
        e = blank(3'd3);
        e.iord   = 1'b1;
        e.mem_rd = (k == 1);
        e.mem_we = (k == 2);
        e.retire = (k == 2) && (i == mst);
        push(i == mst, op, 1'($urandom), e);
      end
    end
    if (k == 0 || k == 1) begin
      e = blank(3'd4);
      e.reg_we = 1'b1; e.retire = 1'b1;
      e.reg_dst = (k == 0); e.mem_to_reg = (k == 1);
      push(1'($urandom), op, 1'($urandom), e);
    end
  endtask

  task automatic check(input string tag, input obs_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_n(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = q.pop_front();
      mem_ready = r.mr; opcode = r.op; zero = r.z; funct = 6'($urandom);
      @(negedge clk);
      check($sformatf("instr%0d_step%0d", r.id, i), r.exp);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  task automatic reset_between_edges(input string tag);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check(tag, blank(3'd0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 check({tag, "_release"}, fetch_exp(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    #12 check("reset_hold", blank(3'd0));
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    add_instr(6'h00, 0, 0, 1'b0, 0); run_all();   // R-type, 4 cycles
    add_instr(6'h23, 2, 3, 1'b0, 0); run_all();   // LW, 10 cycles with stalls
    add_instr(6'h04, 0, 0, 1'b1, 0); run_all();   // BEQ taken
    add_instr(6'h04, 0, 0, 1'b0, 0); run_all();   // BEQ not taken
    add_instr(6'h02, 0, 0, 1'b0, 0); run_all();   // J
    add_instr(6'h11, 0, 0, 1'b0, 0); run_all();   // unknown opcode -> NOP
    add_instr(6'h2B, 1, 0, 1'b0, 0); run_all();   // SW

    add_instr(6'h2B, 0, 3, 1'b0, 0);
    run_n(4);
    reset_between_edges("rst_mid_sw");

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h02;
        default: begin
          op = 6'($urandom);
          while (cls_of(op) != 6) op = 6'($urandom);
        end
      endcase
      add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
    end
    run_all();

    add_instr(6'h3F, 1, 0, 1'b0, 20); run_all();
    reset_between_edges("rst_from_halt");
    add_instr(6'h00, 0, 0, 1'b0, 0); run_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
